mem_access_initiator: RTL

Initiator-side controller for the single-port data memory. Accepts load/store requests (single word or 2–4-word bursts) from the CPU datapath over a valid/ready interface, queues them in a small FIFO, sequences the memory's WR_RD/ADDR/din pins, and returns read data over a valid/ready response channel. It compensates for the memory's built-in read-address offset, so reads and writes to the same request address touch the same word.

---
 rtl/mem_access_initiator_pkg.sv | 22 ++
 rtl/mem_access_initiator_if.sv | 45 ++++
 rtl/mem_access_initiator_fifo.sv | 57 +++++
 rtl/mem_access_initiator.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mem_access_initiator_pkg.sv
// mem_access_pkg
// Shared definitions for the memory access initiator: FSM state encoding,
// WR_RD pin polarity and the default read-address offset the data memory
// applies internally.
package mem_access_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WRITE    = 3'd1,
        ST_RD_ADDR  = 3'd2,
        ST_RD_DATA  = 3'd3,
        ST_RSP_WAIT = 3'd4
    } state_e;

    // Memory WR_RD pin: low writes, high reads.
    localparam logic WR_RD_WRITE = 1'b0;
    localparam logic WR_RD_READ  = 1'b1;

    // The memory adds this to every read address.
    localparam int unsigned DEFAULT_READ_OFFSET = 32'h0000_00F0;

endpackage

// File: rtl/mem_access_initiator_if.sv
// mem_access_initiator_if
// Bundles the request channel, the response channel and the memory pins of
// the initiator.
//   req_*     : CPU request (valid/ready), write/addr/len/wdata payload
//   rsp_*     : read beat response (valid/ready), data and last flag
//   mem_*     : data memory pins (din, ADDR, WR_RD, dout)
// Modports:
//   slave  : the mem_access_initiator itself
//   master : the environment (CPU datapath + memory)
interface mem_access_initiator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_len;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_last;

    logic [DATA_WIDTH-1:0] mem_din;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_wr_rd;
    logic [DATA_WIDTH-1:0] mem_dout;

    modport slave (
        input  req_valid, req_write, req_addr, req_len, req_wdata,
        input  rsp_ready, mem_dout,
        output req_ready, rsp_valid, rsp_data, rsp_last,
        output mem_din, mem_addr, mem_wr_rd
    );

    modport master (
        output req_valid, req_write, req_addr, req_len, req_wdata,
        output rsp_ready, mem_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_last,
        input  mem_din, mem_addr, mem_wr_rd
    );

endinterface

// File: rtl/mem_access_initiator_fifo.sv
// mem_req_fifo
// Synchronous FIFO for queued requests. A push is ignored while full (even in
// a cycle that also pops), a pop is ignored while empty. Read data is the
// current head entry, valid whenever empty_o is low.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/wdata_i: write request and entry
//   pop_i/rdata_o : remove head entry / head entry
//   full_o/empty_o: occupancy flags
module mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[PW-1:0]];

    assign wr_ptr_d = do_push ? wr_ptr_q + (PW+1)'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + (PW+1)'(1) : rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/mem_access_initiator.sv
// mem_access_initiator
// Queues CPU load/store requests and sequences the single-port data memory.
// Stores write the same data to every beat; loads return one response beat
// per word. Read addresses are pre-compensated for the memory's internal
// offset so a load and a store to the same request address hit the same word.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : request, response and memory pins (slave modport)
//   busy_o : FSM active or requests still queued
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | waiting for a queued request; pops it and loads beat regs
// ST_WRITE    | one memory write per cycle until the last beat
// ST_RD_ADDR  | read address presented to the memory
// ST_RD_DATA  | memory data valid; captured into the response register
// ST_RSP_WAIT | response held until the consumer takes it
module mem_access_initiator
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] READ_OFFSET = ADDR_WIDTH'(DEFAULT_READ_OFFSET)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    mem_access_initiator_if.slave  bus,
    output logic                   busy_o
);
    localparam int ENTRY_W = 1 + ADDR_WIDTH + 2 + DATA_WIDTH;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] beat_addr_q, beat_addr_d;
    logic [1:0]            beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_last_q, rsp_last_d;

    logic [ENTRY_W-1:0]    push_entry;
    logic [ENTRY_W-1:0]    pop_entry;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop_write;
    logic [ADDR_WIDTH-1:0] pop_addr;
    logic [1:0]            pop_len;
    logic [DATA_WIDTH-1:0] pop_wdata;

    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  mem_wr_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;

    assign push_entry = {bus.req_write, bus.req_addr, bus.req_len, bus.req_wdata};
    assign {pop_write, pop_addr, pop_len, pop_wdata} = pop_entry;

    mem_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (bus.req_valid),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (pop_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The memory adds READ_OFFSET to read addresses; subtracting it here
    // (mod 2^ADDR_WIDTH) lands the read on the requested word.
    assign rd_addr = beat_addr_q - READ_OFFSET;

    always_comb begin
        state_d     = state_q;
        beat_addr_d = beat_addr_q;
        beat_cnt_d  = beat_cnt_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        fifo_pop    = 1'b0;
        mem_wr_rd   = WR_RD_READ;
        mem_addr    = '0;
        mem_din     = '0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    beat_addr_d = pop_addr;
                    beat_cnt_d  = pop_len;
                    wdata_d     = pop_wdata;
                    state_d     = pop_write ? ST_WRITE : ST_RD_ADDR;
                end
            end
            ST_WRITE: begin
                mem_wr_rd   = WR_RD_WRITE;
                mem_addr    = beat_addr_q;
                mem_din     = wdata_q;
                beat_addr_d = beat_addr_q + ADDR_WIDTH'(1);
                beat_cnt_d  = beat_cnt_q - 2'd1;
                if (beat_cnt_q == 2'd0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                mem_addr = rd_addr;
                state_d  = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                mem_addr    = rd_addr;
                rsp_data_d  = bus.mem_dout;
                rsp_valid_d = 1'b1;
                rsp_last_d  = (beat_cnt_q == 2'd0);
                state_d     = ST_RSP_WAIT;
            end
            ST_RSP_WAIT: begin
                mem_addr = rd_addr;
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_addr_d = beat_addr_q + ADDR_WIDTH'(1);
                        beat_cnt_d  = beat_cnt_q - 2'd1;
                        state_d     = ST_RD_ADDR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            beat_addr_q <= '0;
            beat_cnt_q  <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_addr_q <= beat_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign bus.req_ready = !fifo_full;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;
    assign bus.mem_wr_rd = mem_wr_rd;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_din   = mem_din;
    assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;

endmodule
